// File: rtl/rr_sample_sched.sv
// rr_sample_sched: round-robin / fixed-priority scheduler sharing one sample
// register between NREQ requesters. A winner is granted for HOLD cycles,
// then its data slice is captured into dout with a one-cycle vld pulse.
// Everything runs on clk with enables; there are no derived clocks.
//
// Ports:
//   clk    system clock, all state on posedge
//   reset  synchronous active-high reset
//   req    level-sensitive request per requester
//   data   requester data, slice k = data[k*W +: W]
//   mode   00/10 round-robin, 11 fixed priority, 01 freeze (no new grants)
//   gnt    one-hot grant, zero when idle
//   vld    one-cycle pulse, dout/owner just updated
//   dout   captured data of the last winner
//   owner  index of the last captured requester
//   busy   high while in GRANT or CAPTURE
//   gcount saturating capture count (only with RR_SAMPLE_SCHED_STATS_EN)
//
// Optional feature macro: RR_SAMPLE_SCHED_STATS_EN
module rr_sample_sched #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned W    = 8,
   parameter int unsigned HOLD = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ*W-1:0]        data,
   input  logic [1:0]               mode,
   output logic [NREQ-1:0]          gnt,
   output logic                     vld,
   output logic [W-1:0]             dout,
   output logic [$clog2(NREQ)-1:0]  owner,
   output logic                     busy
`ifdef RR_SAMPLE_SCHED_STATS_EN
   ,
   output logic [7:0]               gcount
`endif
);

   localparam int unsigned IW = $clog2(NREQ);
   localparam int unsigned CW = 4;
   localparam logic [1:0]  MODE_FREEZE = 2'b01;
   localparam logic [1:0]  MODE_FIXED  = 2'b11;

   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_CAPTURE} state_e;

   state_e          state_q, state_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [IW-1:0]   win_q, win_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic            vld_q, vld_d;
   logic [W-1:0]    dout_q, dout_d;
   logic [IW-1:0]   owner_q, owner_d;
   logic            busy_q, busy_d;
`ifdef RR_SAMPLE_SCHED_STATS_EN
   logic [7:0]      gcount_q, gcount_d;
`endif

   logic [IW-1:0]   pick_idx;
   logic            pick_found;
   int unsigned     cand;

   // Winner pick: first set req scanning upward from ptr (with wrap), or from 0 in fixed mode
   always_comb begin
      pick_idx   = '0;
      pick_found = 1'b0;
      cand       = 0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (mode == MODE_FIXED) begin
            cand = i;
         end else begin
            cand = 32'(ptr_q) + i;
            if (cand >= NREQ) cand = cand - NREQ;
         end
         if (!pick_found && req[IW'(cand)]) begin
            pick_found = 1'b1;
            pick_idx   = IW'(cand);
         end
      end
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      win_d   = win_q;
      gnt_d   = gnt_q;
      vld_d   = 1'b0;
      dout_d  = dout_q;
      owner_d = owner_q;
      busy_d  = busy_q;
`ifdef RR_SAMPLE_SCHED_STATS_EN
      gcount_d = gcount_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (pick_found && (mode != MODE_FREEZE)) begin
               win_d   = pick_idx;
               gnt_d   = NREQ'(1) << pick_idx;
               cnt_d   = CW'(HOLD - 1);
               busy_d  = 1'b1;
               state_d = S_GRANT;
            end
         end
         S_GRANT: begin
            // Grant is held regardless of req/mode changes until the count expires
            if (cnt_q == '0) begin
               gnt_d   = '0;
               state_d = S_CAPTURE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_CAPTURE: begin
            dout_d  = data[32'(win_q)*W +: W];
            owner_d = win_q;
            vld_d   = 1'b1;
            ptr_d   = (win_q == IW'(NREQ - 1)) ? '0 : win_q + IW'(1);
            busy_d  = 1'b0;
            state_d = S_IDLE;
`ifdef RR_SAMPLE_SCHED_STATS_EN
            if (gcount_q != 8'hFF) gcount_d = gcount_q + 8'd1;
`endif
         end
         default: begin
            gnt_d   = '0;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State register, synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
         win_q   <= '0;
         gnt_q   <= '0;
         vld_q   <= 1'b0;
         dout_q  <= '0;
         owner_q <= '0;
         busy_q  <= 1'b0;
`ifdef RR_SAMPLE_SCHED_STATS_EN
         gcount_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         win_q   <= win_d;
         gnt_q   <= gnt_d;
         vld_q   <= vld_d;
         dout_q  <= dout_d;
         owner_q <= owner_d;
         busy_q  <= busy_d;
`ifdef RR_SAMPLE_SCHED_STATS_EN
         gcount_q <= gcount_d;
`endif
      end
   end

   assign gnt   = gnt_q;
   assign vld   = vld_q;
   assign dout  = dout_q;
   assign owner = owner_q;
   assign busy  = busy_q;
`ifdef RR_SAMPLE_SCHED_STATS_EN
   assign gcount = gcount_q;
`endif

endmodule

// File: tb/tb_rr_sample_sched.sv
// Self-checking bench for rr_sample_sched: expected captures are queued when
// stimulus is driven and compared against each vld pulse.
module tb_rr_sample_sched;

   localparam int unsigned NREQ = 4;
   localparam int unsigned W    = 8;
   localparam int unsigned HOLD = 2;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [NREQ-1:0]  req = '0;
   logic [NREQ*W-1:0] data = '0;
   logic [1:0]       mode = 2'b00;
   logic [NREQ-1:0]  gnt;
   logic             vld;
   logic [W-1:0]     dout;
   logic [1:0]       owner;
   logic             busy;
`ifdef RR_SAMPLE_SCHED_STATS_EN
   logic [7:0]       gcount;
`endif

   rr_sample_sched #(.NREQ(NREQ), .W(W), .HOLD(HOLD)) dut (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .data  (data),
      .mode  (mode),
      .gnt   (gnt),
      .vld   (vld),
      .dout  (dout),
      .owner (owner),
      .busy  (busy)
`ifdef RR_SAMPLE_SCHED_STATS_EN
      ,
      .gcount(gcount)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] owner;
      logic [7:0] dout;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   last_vld = 0;
   logic have_last = 1'b0;
   logic chk_period = 1'b0;
   logic saw_g3 = 1'b0;
   logic watch_g3 = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic push_exp(input logic [1:0] o, input logic [7:0] d);
      exp_t e;
      e.owner = o;
      e.dout  = d;
      sb_q.push_back(e);
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while (sb_q.size() != 0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      check_eq({tag, "_drain"}, 32'(sb_q.size()), 0);
      repeat (3) @(negedge clk);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor: scoreboard compare on vld, grant sanity every cycle
   always @(negedge clk) begin
      if (!reset) check_eq("gnt_onehot0", 32'($onehot0(gnt)), 1);
      if (watch_g3 && gnt[3]) saw_g3 <= 1'b1;
      if (!chk_period) have_last <= 1'b0;
      if (vld === 1'b1) begin
         if (sb_q.size() == 0) begin
            check_eq("vld_unexpected", 1, 0);
         end else begin
            check_eq("dout", 32'(dout), 32'(sb_q[0].dout));
            check_eq("owner", 32'(owner), 32'(sb_q[0].owner));
            void'(sb_q.pop_front());
         end
         if (chk_period && have_last) check_eq("vld_period", 32'(cyc - last_vld), 4);
         last_vld  <= cyc;
         have_last <= chk_period;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset held with all requests active
      reset = 1'b1;
      req   = 4'b1111;
      data  = 32'h44332211;
      repeat (2) begin
         @(negedge clk);
         check_eq("rst_gnt", 32'(gnt), 0);
         check_eq("rst_vld", 32'(vld), 0);
         check_eq("rst_dout", 32'(dout), 0);
         check_eq("rst_busy", 32'(busy), 0);
         check_eq("rst_owner", 32'(owner), 0);
      end
      req   = '0;
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Single request, latency and hold timing
      mode = 2'b00;
      data = 32'h00A50000 | 32'h3C000F0E;
      req  = 4'b0100;
      push_exp(2'd2, 8'hA5);
      @(posedge clk); #1 req = '0;
      @(negedge clk); check_eq("s2_gnt_c1", 32'(gnt), 32'h4);
      check_eq("s2_busy_c1", 32'(busy), 1);
      @(negedge clk); check_eq("s2_gnt_c2", 32'(gnt), 32'h4);
      @(negedge clk); check_eq("s2_gnt_c3", 32'(gnt), 0);
      check_eq("s2_busy_c3", 32'(busy), 1);
      @(negedge clk); check_eq("s2_vld_c4", 32'(vld), 1);
      check_eq("s2_busy_c4", 32'(busy), 0);
      drain("s2");

      // Fresh pointer, all requesting: rotation 0,1,2,3,0 every 4 cycles
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      data  = 32'h44332211;
      chk_period = 1'b1;
      push_exp(2'd0, 8'h11);
      push_exp(2'd1, 8'h22);
      push_exp(2'd2, 8'h33);
      push_exp(2'd3, 8'h44);
      push_exp(2'd0, 8'h11);
      req = 4'b1111;
      repeat (17) @(posedge clk);
      #1 req = '0;
      drain("s3");
      chk_period = 1'b0;

      // Fixed priority: requester 1 always beats 3
      mode = 2'b11;
      data = 32'h5A6B7C8D;
      repeat (3) push_exp(2'd1, 8'h7C);
      watch_g3 = 1'b1;
      req = 4'b1010;
      repeat (9) @(posedge clk);
      #1 req = '0;
      drain("s4");
      watch_g3 = 1'b0;
      check_eq("s4_no_g3", 32'(saw_g3), 0);

      // Freeze blocks grants; release grants next cycle; mid-grant freeze ignored
      mode = 2'b01;
      data = 32'h112233C3;
      req  = 4'b0001;
      repeat (4) begin
         @(negedge clk);
         check_eq("s5_frz_gnt", 32'(gnt), 0);
         check_eq("s5_frz_busy", 32'(busy), 0);
      end
      mode = 2'b00;
      push_exp(2'd0, 8'hC3);
      @(posedge clk); #1 req = '0;
      mode = 2'b01;
      @(negedge clk); check_eq("s5_gnt", 32'(gnt), 32'h1);
      drain("s5");
      mode = 2'b00;

      // Reset during GRANT aborts the capture; requester 1 regranted afterwards
      data = 32'h0000E700;
      req  = 4'b0010;
      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk); check_eq("s6_gnt_pre", 32'(gnt), 32'h2);
      @(posedge clk); #1 reset = 1'b0;
      push_exp(2'd1, 8'hE7);
      @(negedge clk);
      check_eq("s6_gnt_rst", 32'(gnt), 0);
      check_eq("s6_busy_rst", 32'(busy), 0);
      check_eq("s6_vld_rst", 32'(vld), 0);
      @(posedge clk); #1 req = '0;
      @(negedge clk); check_eq("s6_gnt_post", 32'(gnt), 32'h2);
      drain("s6");

      check_eq("sb_empty", 32'(sb_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
